// File: rtl/viewport_params_seq_if.sv
// Handshake and result bus for the sequential viewport-parameter generator.
// The master side requests and receives parameters; the slave side is the generator.
interface viewport_params_seq_if #(
  parameter int W = 20
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] lookat_rel_x;
  logic signed [W-1:0] lookat_rel_y;
  logic signed [W-1:0] lookat_rel_z;
  logic signed [W-1:0] lookat_h_rel_x;
  logic signed [W-1:0] lookat_h_rel_y;
  logic                frame_sync;
  logic                busy;
  logic                out_valid;
  logic signed [W-1:0] vp_u_x;
  logic signed [W-1:0] vp_u_y;
  logic signed [W-1:0] vp_u_z;
  logic signed [W-1:0] vp_v_x;
  logic signed [W-1:0] vp_v_y;
  logic signed [W-1:0] vp_v_z;
  logic signed [W-1:0] vp_origin_x;
  logic signed [W-1:0] vp_origin_y;
  logic signed [W-1:0] vp_origin_z;
  logic signed [W-1:0] towards_h_x;
  logic signed [W-1:0] towards_h_y;

  modport master (
    output in_valid, lookat_rel_x, lookat_rel_y, lookat_rel_z,
           lookat_h_rel_x, lookat_h_rel_y, frame_sync,
    input  in_ready, busy, out_valid,
           vp_u_x, vp_u_y, vp_u_z, vp_v_x, vp_v_y, vp_v_z,
           vp_origin_x, vp_origin_y, vp_origin_z, towards_h_x, towards_h_y
  );

  modport slave (
    input  in_valid, lookat_rel_x, lookat_rel_y, lookat_rel_z,
           lookat_h_rel_x, lookat_h_rel_y, frame_sync,
    output in_ready, busy, out_valid,
           vp_u_x, vp_u_y, vp_u_z, vp_v_x, vp_v_y, vp_v_z,
           vp_origin_x, vp_origin_y, vp_origin_z, towards_h_x, towards_h_y
  );
endinterface

// File: rtl/viewport_params_seq.sv
// Sequential viewport-parameter generator: cross product, shared restoring divider,
// shadow registers committed atomically (optionally on frame_sync).
module viewport_params_seq #(
  parameter int W           = 20,
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int UNIT        = 225,
  parameter int SYNC_COMMIT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  viewport_params_seq_if.slave bus
);

  localparam int DW = 2*W + 2;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0]        LAST   = CW'(DW);
  localparam logic [DW:0]          UNIT_W = (DW+1)'(UNIT);
  localparam logic signed [DW-1:0] HD     = DW'(H_DISP);
  localparam logic signed [DW-1:0] VD     = DW'(V_DISP);

  typedef enum logic [2:0] {IDLE, CROSS, DIVV, ORG, DIVO, WAIT_SYNC, COMMIT} state_t;

  function automatic logic signed [DW-1:0] sx(input logic signed [W-1:0] a);
    return {{(DW-W){a[W-1]}}, a};
  endfunction

  // Halve with truncation toward zero: bias negatives by one before the arithmetic shift.
  function automatic logic signed [DW-1:0] half(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] s;
    s = x + {{(DW-1){1'b0}}, x[DW-1]};
    return s >>> 1;
  endfunction

  state_t              state;
  logic [1:0]          comp;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] l_q [3];
  logic signed [W-1:0] lh_x_q;
  logic signed [W-1:0] lh_y_q;
  logic signed [DW-1:0] n_q    [3];
  logic signed [DW-1:0] v_full [3];
  logic signed [DW-1:0] t_q    [3];
  logic [DW:0]         rem;
  logic [DW-1:0]       quo;
  logic                neg;
  logic signed [W-1:0] u_sh   [3];
  logic signed [W-1:0] v_sh   [3];
  logic signed [W-1:0] org_sh [3];
  logic signed [W-1:0] th_sh  [2];
  logic signed [W-1:0] u_o    [3];
  logic signed [W-1:0] v_o    [3];
  logic signed [W-1:0] org_o  [3];
  logic signed [W-1:0] th_o   [2];
  logic                busy_q;
  logic                out_valid_q;

  logic signed [DW-1:0] ux, uy, uz, lx, ly, lz;
  logic signed [DW-1:0] nx, ny, nz, tx, ty, tz;
  logic signed [DW-1:0] div_src, div_res, org_full;
  logic [DW:0]          rem_sh, rem_nx;
  logic [DW-1:0]        quo_nx;
  logic                 ge;

  always_comb begin
    ux = sx(lh_y_q);
    uy = -sx(lh_x_q);
    uz = '0;
    lx = sx(l_q[0]);
    ly = sx(l_q[1]);
    lz = sx(l_q[2]);
    nx = uy*lz - uz*ly;
    ny = uz*lx - ux*lz;
    nz = ux*ly - uy*lx;
    tx = half(-(ux*HD) + v_full[0]*VD);
    ty = half(-(uy*HD) + v_full[1]*VD);
    tz = half(-(uz*HD) + v_full[2]*VD);
  end

  // One restoring step on magnitudes; the quotient sign is reapplied on the final step.
  always_comb begin
    div_src  = (state == DIVO) ? t_q[comp] : n_q[comp];
    rem_sh   = {rem[DW-1:0], quo[DW-1]};
    ge       = (rem_sh >= UNIT_W);
    rem_nx   = ge ? (rem_sh - UNIT_W) : rem_sh;
    quo_nx   = {quo[DW-2:0], ge};
    div_res  = neg ? -$signed(quo_nx) : $signed(quo_nx);
    org_full = (sx(l_q[comp]) + div_res) <<< 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      comp        <= '0;
      cnt         <= '0;
      lh_x_q      <= '0;
      lh_y_q      <= '0;
      rem         <= '0;
      quo         <= '0;
      neg         <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        l_q[i]    <= '0;
        n_q[i]    <= '0;
        v_full[i] <= '0;
        t_q[i]    <= '0;
        u_sh[i]   <= '0;
        v_sh[i]   <= '0;
        org_sh[i] <= '0;
        u_o[i]    <= '0;
        v_o[i]    <= '0;
        org_o[i]  <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        th_sh[i] <= '0;
        th_o[i]  <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            l_q[0] <= bus.lookat_rel_x;
            l_q[1] <= bus.lookat_rel_y;
            l_q[2] <= bus.lookat_rel_z;
            lh_x_q <= bus.lookat_h_rel_x;
            lh_y_q <= bus.lookat_h_rel_y;
            busy_q <= 1'b1;
            state  <= CROSS;
          end
        end
        CROSS: begin
          n_q[0]   <= nx;
          n_q[1]   <= ny;
          n_q[2]   <= nz;
          u_sh[0]  <= lh_y_q;
          u_sh[1]  <= -lh_x_q;
          u_sh[2]  <= '0;
          th_sh[0] <= lh_x_q;
          th_sh[1] <= lh_y_q;
          comp     <= '0;
          cnt      <= '0;
          state    <= DIVV;
        end
        DIVV, DIVO: begin
          if (cnt == '0) begin
            rem <= '0;
            neg <= div_src[DW-1];
            quo <= div_src[DW-1] ? -div_src : div_src;
            cnt <= cnt + 1'b1;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            if (cnt == LAST) begin
              if (state == DIVV) begin
                v_full[comp] <= div_res;
                v_sh[comp]   <= div_res[W-1:0];
              end else begin
                org_sh[comp] <= org_full[W-1:0];
              end
              cnt <= '0;
              if (comp == 2'd2) begin
                comp <= '0;
                if (state == DIVV)
                  state <= ORG;
                else
                  state <= (SYNC_COMMIT != 0) ? WAIT_SYNC : COMMIT;
              end else begin
                comp <= comp + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ORG: begin
          t_q[0] <= tx;
          t_q[1] <= ty;
          t_q[2] <= tz;
          state  <= DIVO;
        end
        WAIT_SYNC: begin
          if (bus.frame_sync)
            state <= COMMIT;
        end
        COMMIT: begin
          u_o         <= u_sh;
          v_o         <= v_sh;
          org_o       <= org_sh;
          th_o        <= th_sh;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.vp_u_x      = u_o[0];
  assign bus.vp_u_y      = u_o[1];
  assign bus.vp_u_z      = u_o[2];
  assign bus.vp_v_x      = v_o[0];
  assign bus.vp_v_y      = v_o[1];
  assign bus.vp_v_z      = v_o[2];
  assign bus.vp_origin_x = org_o[0];
  assign bus.vp_origin_y = org_o[1];
  assign bus.vp_origin_z = org_o[2];
  assign bus.towards_h_x = th_o[0];
  assign bus.towards_h_y = th_o[1];

endmodule

// File: tb/tb_viewport_params_seq.sv
// Directed bench: an immediate-commit instance and a frame-synchronised instance
// driven with hand-computed look-at vectors.
module tb_viewport_params_seq;

  localparam int W = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  viewport_params_seq_if #(.W(W)) if0 ();
  viewport_params_seq_if #(.W(W)) if1 ();

  viewport_params_seq #(.W(W), .H_DISP(1280), .V_DISP(720), .UNIT(225), .SYNC_COMMIT(0)) dut_imm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  viewport_params_seq #(.W(W), .H_DISP(1280), .V_DISP(720), .UNIT(225), .SYNC_COMMIT(1)) dut_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
    end
  endtask

  // Drives one request into the immediate-commit instance and checks latency and results.
  task automatic applyStimulus(input int lx, input int ly, input int lz, input int hx, input int hy,
                               input int evx, input int evy, input int evz,
                               input int eox, input int eoy, input int eoz, input bit hold);
    int lat;
    lat = 0;
    @(negedge clk);
    if0.in_valid       = 1'b1;
    if0.lookat_rel_x   = W'(lx);
    if0.lookat_rel_y   = W'(ly);
    if0.lookat_rel_z   = W'(lz);
    if0.lookat_h_rel_x = W'(hx);
    if0.lookat_h_rel_y = W'(hy);
    @(posedge clk);
    #1;
    if (!hold) if0.in_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 100) begin
        checkOutput("busy_mid", int'(if0.busy), 1);
        checkOutput("in_ready_mid", int'(if0.in_ready), 0);
      end
      if (if0.out_valid) begin
        lat = n;
        break;
      end
    end
    if0.in_valid = 1'b0;
    checkOutput("latency", lat, 261);
    checkOutput("busy_done", int'(if0.busy), 0);
    checkOutput("u_x", int'(if0.vp_u_x), hy);
    checkOutput("u_y", int'(if0.vp_u_y), -hx);
    checkOutput("u_z", int'(if0.vp_u_z), 0);
    checkOutput("v_x", int'(if0.vp_v_x), evx);
    checkOutput("v_y", int'(if0.vp_v_y), evy);
    checkOutput("v_z", int'(if0.vp_v_z), evz);
    checkOutput("org_x", int'(if0.vp_origin_x), eox);
    checkOutput("org_y", int'(if0.vp_origin_y), eoy);
    checkOutput("org_z", int'(if0.vp_origin_z), eoz);
    checkOutput("th_x", int'(if0.towards_h_x), hx);
    checkOutput("th_y", int'(if0.towards_h_y), hy);
    @(posedge clk);
    #1;
    checkOutput("out_valid_pulse", int'(if0.out_valid), 0);
    checkOutput("no_second_accept", int'(if0.busy), 0);
    checkOutput("hold_org_x", int'(if0.vp_origin_x), eox);
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    seen   = 0;
    rst_n  = 1'b0;
    if0.in_valid = 1'b0; if0.frame_sync = 1'b0;
    if0.lookat_rel_x = '0; if0.lookat_rel_y = '0; if0.lookat_rel_z = '0;
    if0.lookat_h_rel_x = '0; if0.lookat_h_rel_y = '0;
    if1.in_valid = 1'b0; if1.frame_sync = 1'b0;
    if1.lookat_rel_x = '0; if1.lookat_rel_y = '0; if1.lookat_rel_z = '0;
    if1.lookat_h_rel_x = '0; if1.lookat_h_rel_y = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(if0.out_valid), 0);
    checkOutput("rst_busy", int'(if0.busy), 0);
    checkOutput("rst_org_y", int'(if0.vp_origin_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_rst", int'(if0.in_ready), 1);

    // Frame-synchronised instance: early frame_sync is dropped, commit follows a later one.
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.lookat_rel_x = 20'sd225;
    if1.lookat_h_rel_x = 20'sd225;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (if1.out_valid) seen = 1;
      if1.frame_sync = (i == 99);
    end
    checkOutput("sync_no_commit", seen, 0);
    checkOutput("sync_busy", int'(if1.busy), 1);
    checkOutput("sync_hold_v_z", int'(if1.vp_v_z), 0);
    checkOutput("sync_hold_org_x", int'(if1.vp_origin_x), 0);
    @(negedge clk);
    if1.frame_sync = 1'b1;
    @(posedge clk);
    #1;
    if1.frame_sync = 1'b0;
    checkOutput("sync_sample_edge", int'(if1.out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("sync_out_valid", int'(if1.out_valid), 1);
    checkOutput("sync_u_y", int'(if1.vp_u_y), -225);
    checkOutput("sync_v_z", int'(if1.vp_v_z), 225);
    checkOutput("sync_org_x", int'(if1.vp_origin_x), 450);
    checkOutput("sync_org_y", int'(if1.vp_origin_y), 1280);
    checkOutput("sync_org_z", int'(if1.vp_origin_z), 720);

    // Immediate-commit instance, directed vectors.
    applyStimulus(225, 0, 0, 225, 0,     0, 0, 225,   450, 1280, 720, 1'b1);
    applyStimulus(0, 225, 0, 0, 225,     0, 0, 225,   -1280, 450, 720, 1'b0);
    applyStimulus(1, 0, 1, 1, 0,         0, 0, 0,     2, 4, 2, 1'b0);
    applyStimulus(100, -50, 30, 100, -50, -13, 6, 55, 442, 488, 236, 1'b0);

    // Reset during a computation aborts it and clears the committed outputs.
    @(negedge clk);
    if0.in_valid = 1'b1;
    if0.lookat_rel_x = 20'sd225; if0.lookat_rel_y = '0; if0.lookat_rel_z = '0;
    if0.lookat_h_rel_x = 20'sd225; if0.lookat_h_rel_y = '0;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(if0.busy), 0);
    checkOutput("abort_org_x", int'(if0.vp_origin_x), 0);
    checkOutput("abort_v_x", int'(if0.vp_v_x), 0);
    checkOutput("abort_th_x", int'(if0.towards_h_x), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (if0.out_valid) seen = 1;
    end
    checkOutput("abort_no_commit", seen, 0);
    checkOutput("abort_in_ready", int'(if0.in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viewport_params_seq.md
Name: viewport_params_seq

Overview:
- Sequential, parametrised successor to the combinational viewport-parameter generator.
- Takes the camera look-at vector and its horizontal projection, both scaled so that unit length = UNIT.
- Computes the screen basis vectors u and v and the viewport origin using one shared iterative signed divider.
- Holds results in shadow registers and commits them atomically, optionally only on a frame-sync pulse, so the ray generator never sees parameters change mid-frame.

Parameters:
- W, 20, signed width of every vector input and output.
- H_DISP, 1280, horizontal resolution in pixels.
- V_DISP, 720, vertical resolution in pixels.
- UNIT, 225, fixed-point length of a unit vector; divisor for all normalisations.
- SYNC_COMMIT, 1, 1 = commit waits for frame_sync; 0 = commit immediately after compute.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request; look-at inputs are valid this cycle.
- in_ready  out  1  high only in IDLE.
- lookat_rel_x, lookat_rel_y, lookat_rel_z  in  W each  signed look-at vector.
- lookat_h_rel_x, lookat_h_rel_y  in  W each  signed horizontal look-at vector.
- frame_sync  in  1  one-cycle pulse at frame boundary (vsync).
- busy  out  1  high from accept until commit.
- out_valid  out  1  one-cycle pulse on the commit cycle.
- vp_u_x, vp_u_y, vp_u_z  out  W each  signed screen-horizontal basis vector.
- vp_v_x, vp_v_y, vp_v_z  out  W each  signed screen-vertical basis vector.
- vp_origin_x, vp_origin_y, vp_origin_z  out  W each  signed viewport origin.
- towards_h_x, towards_h_y  out  W each  signed horizontal facing vector.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, out_valid 0, busy 0, FSM in IDLE, shadow registers 0; in_ready 1 once reset is released.
- Reset asserted mid-operation: computation aborts immediately, everything clears, no commit occurs.
- Accept: a handshake completes when in_valid && in_ready. All five look-at inputs are latched into internal registers on that edge. in_valid while busy is ignored, not queued.
- Internal width: DW = 2*W+2. All products and differences are formed at DW bits, sign-extended.
- Definitions:
  - u = (lh_y, -lh_x, 0).
  - Nx = u_y*l_z - u_z*l_y; Ny = u_z*l_x - u_x*l_z; Nz = u_x*l_y - u_y*l_x.
  - v = trunc(N/UNIT).
  - T = trunc((-u*H_DISP + v*V_DISP)/2) per axis.
  - origin = (l + trunc(T/UNIT)) << 1.
  - All divisions truncate toward zero (Verilog signed "/" semantics).
  - Final results are truncated to W bits (two's-complement wrap, no saturation).
- FSM states and cycle counts:
  - IDLE: on accept -> CROSS.
  - CROSS (1 cycle): register Nx, Ny, Nz.
  - DIVV (3*(DW+1) cycles): divide Nx, Ny, Nz by UNIT in sequence. Each divide takes 1 load cycle plus DW restoring iterations on magnitudes; sign is applied afterward.
  - ORG (1 cycle): register Tx, Ty, Tz.
  - DIVO (3*(DW+1) cycles): divide Tx, Ty, Tz by UNIT; form the origin into shadow registers.
  - Exit from DIVO: to WAIT if SYNC_COMMIT=1, else to COMMIT.
  - WAIT: commit on the first cycle frame_sync is sampled high. A frame_sync pulse seen before WAIT is not remembered.
  - COMMIT (1 cycle): copy shadow to outputs, pulse out_valid, deassert busy -> IDLE.
- Latency, SYNC_COMMIT=0: accept edge to out_valid = 6*DW+9 cycles (261 for W=20).
- Latency, SYNC_COMMIT=1: plus the wait, with 1 cycle from the frame_sync sample to out_valid.
- Output stability: outputs change only on a COMMIT edge and hold between commits.
- u is always committed with vp_u_z = 0.
- towards_h equals the latched lookat_h.

Test Plan:
- Forward: l=(225,0,0), lh=(225,0), SYNC_COMMIT=0 -> after 261 cycles out_valid pulses; u=(0,-225,0), v=(0,0,225), origin=(450,1280,720), towards_h=(225,0).
- Rotated +y: l=(0,225,0), lh=(0,225) -> u=(225,0,0), v=(0,0,225), origin=(-1280,450,720); checks negative truncation path.
- Truncation toward zero: l=(1,0,1), lh=(1,0) -> v=(0,0,0) (not -1), origin=(2,4,2).
- Sync gating, SYNC_COMMIT=1:
  - frame_sync pulsed at cycle 100 -> ignored, no commit.
  - Outputs hold their old values until a frame_sync after cycle 261; out_valid comes 1 cycle after that pulse.
- Busy and reset:
  - in_valid held high during compute -> in_ready=0, no second accept.
  - rst_n low at cycle 50 -> all outputs 0, out_valid never pulses.
  - in_ready=1 after release.
